mbist_ctrl_n: RTL and testbench

- Parametrised March C- memory-BIST controller serving NUM_BANKS single-port synchronous RAM banks with a common address and write-data bus.
- Per-bank compare and fail capture included.
- Successor to the fixed two-bank data-cache controller: generalised bank count, address and data width; adds checkerboard background, first-fail address capture and per-bank fail flags.
- Instantiated in RAM tops (dcram, icram, tag RAMs) between the scan/test interface and the RAM bist_* ports.

---
 rtl/mbist_pkg.sv | 44 ++++
 rtl/mbist_cmp.sv | 24 ++
 rtl/mbist_ctrl_n.sv | 180 ++++++++++++++++++
 tb/tb_mbist_ctrl_n.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mbist_pkg.sv
// Shared types and constants for the March C- memory-BIST controller:
// FSM states, bist_mode encodings, the march element table and the checkerboard base.
package mbist_pkg;

    typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_t;

    localparam logic [1:0] ModeOff     = 2'b00;
    localparam logic [1:0] ModeSolid   = 2'b01;
    localparam logic [1:0] ModeChecker = 2'b10;
    localparam logic [1:0] ModeBoth    = 2'b11;

    localparam logic [2:0] LastElem = 3'd5;

    // wr/pol are indexed by op number within the element (bit 0 = first op).
    typedef struct packed {
        logic       down;
        logic       two_ops;
        logic [1:0] wr;
        logic [1:0] pol;
    } march_elem_t;

    function automatic march_elem_t march_elem(input logic [2:0] idx);
        march_elem_t e;
        case (idx)
            3'd0:    e = '{down: 1'b0, two_ops: 1'b0, wr: 2'b01, pol: 2'b00}; // w0
            3'd1:    e = '{down: 1'b0, two_ops: 1'b1, wr: 2'b10, pol: 2'b10}; // r0,w1
            3'd2:    e = '{down: 1'b0, two_ops: 1'b1, wr: 2'b10, pol: 2'b01}; // r1,w0
            3'd3:    e = '{down: 1'b1, two_ops: 1'b1, wr: 2'b10, pol: 2'b10}; // r0,w1
            3'd4:    e = '{down: 1'b1, two_ops: 1'b1, wr: 2'b10, pol: 2'b01}; // r1,w0
            default: e = '{down: 1'b1, two_ops: 1'b0, wr: 2'b00, pol: 2'b00}; // r0
        endcase
        return e;
    endfunction

    function automatic logic elem_down(input logic [2:0] idx);
        return idx >= 3'd3;
    endfunction

    // Bit bit_idx of the checkerboard base {..0101}.
    function automatic logic checker_base(input int unsigned bit_idx);
        return (bit_idx % 2) == 0;
    endfunction

endpackage

// File: rtl/mbist_cmp.sv
// Per-bank read-data comparator with a sticky, registered fail bit.
module mbist_cmp #(
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              bist_reset,
    input  logic [DATA_W-1:0] rdata,
    input  logic [DATA_W-1:0] expected,
    input  logic              cmp_valid,
    output logic              hit,
    output logic              fail
);

    assign hit = cmp_valid && (rdata != expected);

    always_ff @(posedge clk) begin
        if (bist_reset) begin
            fail <= 1'b0;
        end else if (hit) begin
            fail <= 1'b1;
        end
    end

endmodule

// File: rtl/mbist_ctrl_n.sv
// March C- MBIST controller for NUM_BANKS RAM banks sharing address/write-data buses.
// Define MBIST_STOP_ON_FAIL_EN to end the run on the first miscompare.
module mbist_ctrl_n
    import mbist_pkg::*;
#(
    parameter int unsigned NUM_BANKS = 2,
    parameter int unsigned ADDR_W    = 11,
    parameter int unsigned DATA_W    = 32
) (
    input  logic                          clk,
    input  logic                          bist_reset,
    input  logic                          test_mode,
    input  logic [1:0]                    bist_mode,
    input  logic [NUM_BANKS*DATA_W-1:0]   bank_rdata,
    output logic [ADDR_W-1:0]             bist_addr,
    output logic [DATA_W-1:0]             bist_wdata,
    output logic                          bist_we,
    output logic                          bist_on,
    output logic                          done,
    output logic                          error,
    output logic [NUM_BANKS-1:0]          fail_bank,
    output logic [ADDR_W-1:0]             fail_addr
);

    localparam logic [ADDR_W-1:0] AddrMax = '1;

    state_t            state_q;
    logic [2:0]        elem_q;
    logic              op_q;
    logic [ADDR_W-1:0] addr_q;
    logic              bg_q;
    logic [1:0]        mode_q;
    logic              drain_q;
    logic              rd_q;
    logic              cmp_valid_q;
    logic [DATA_W-1:0] cmp_exp_q;
    logic [ADDR_W-1:0] cmp_addr_q;
    logic [NUM_BANKS-1:0] hit;

    march_elem_t       el;
    logic              op_wr;
    logic              last_op;
    logic              addr_end;
    logic              nxt_down;
    logic [DATA_W-1:0] bg_pat;
    logic [DATA_W-1:0] op_data;

    always_comb begin
        el       = march_elem(elem_q);
        op_wr    = el.wr[op_q];
        last_op  = (op_q == el.two_ops);
        addr_end = el.down ? (addr_q == '0) : (addr_q == AddrMax);
        nxt_down = elem_down(elem_q + 3'd1);
        bg_pat   = '0;
        if (bg_q) begin
            for (int unsigned i = 0; i < DATA_W; i++) begin
                bg_pat[i] = checker_base(i) ^ addr_q[0];
            end
        end
        op_data = el.pol[op_q] ? ~bg_pat : bg_pat;
    end

    assign error = |fail_bank;

    // Sequencer state runs one cycle ahead of the registered bus outputs; the read
    // data returns one cycle after the bus shows the read, hence the cmp_* stage.
    always_ff @(posedge clk) begin
        if (bist_reset) begin
            state_q     <= StIdle;
            elem_q      <= '0;
            op_q        <= 1'b0;
            addr_q      <= '0;
            bg_q        <= 1'b0;
            mode_q      <= ModeOff;
            drain_q     <= 1'b0;
            rd_q        <= 1'b0;
            cmp_valid_q <= 1'b0;
            cmp_exp_q   <= '0;
            cmp_addr_q  <= '0;
            bist_addr   <= '0;
            bist_wdata  <= '0;
            bist_we     <= 1'b0;
            bist_on     <= 1'b0;
            done        <= 1'b0;
            fail_addr   <= '0;
        end else begin
            done        <= (state_q == StDone);
            bist_on     <= (state_q == StRun) || (state_q == StDrain);
            bist_we     <= 1'b0;
            rd_q        <= 1'b0;
            cmp_valid_q <= rd_q;
            cmp_exp_q   <= bist_wdata;
            cmp_addr_q  <= bist_addr;
            if (|hit && !error) begin
                fail_addr <= cmp_addr_q;
            end

            unique case (state_q)
                StIdle: begin
                    if (test_mode && bist_mode != ModeOff) begin
                        state_q <= StRun;
                        elem_q  <= '0;
                        op_q    <= 1'b0;
                        addr_q  <= '0;
                        drain_q <= 1'b0;
                        mode_q  <= bist_mode;
                        bg_q    <= (bist_mode == ModeChecker);
                    end
                end
                StRun: begin
                    bist_addr  <= addr_q;
                    bist_wdata <= op_data;
                    bist_we    <= op_wr;
                    rd_q       <= !op_wr;
                    if (!last_op) begin
                        op_q <= 1'b1;
                    end else begin
                        op_q <= 1'b0;
                        if (!addr_end) begin
                            addr_q <= el.down ? addr_q - 1'b1 : addr_q + 1'b1;
                        end else if (elem_q == LastElem) begin
                            state_q <= StDrain;
                        end else begin
                            elem_q <= elem_q + 3'd1;
                            addr_q <= nxt_down ? AddrMax : '0;
                        end
                    end
                end
                StDrain: begin
                    // Second pass waits one extra cycle so pass one's last compare retires.
                    if (mode_q == ModeBoth && !bg_q) begin
                        if (!drain_q) begin
                            drain_q <= 1'b1;
                        end else begin
                            state_q <= StRun;
                            bg_q    <= 1'b1;
                            elem_q  <= '0;
                            op_q    <= 1'b0;
                            addr_q  <= '0;
                            drain_q <= 1'b0;
                        end
                    end else begin
                        state_q <= StDone;
                    end
                end
                StDone: begin
                    if (bist_mode == ModeOff) begin
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase

            if ((state_q == StRun || state_q == StDrain) && !test_mode) begin
                state_q <= StIdle;
            end
`ifdef MBIST_STOP_ON_FAIL_EN
            else if ((state_q == StRun || state_q == StDrain) && |hit) begin
                state_q <= StDone;
            end
`else
`endif
        end
    end

    for (genvar b = 0; b < NUM_BANKS; b++) begin : g_cmp
        mbist_cmp #(
            .DATA_W(DATA_W)
        ) u_cmp (
            .clk       (clk),
            .bist_reset(bist_reset),
            .rdata     (bank_rdata[b*DATA_W +: DATA_W]),
            .expected  (cmp_exp_q),
            .cmp_valid (cmp_valid_q),
            .hit       (hit[b]),
            .fail      (fail_bank[b])
        );
    end

endmodule

// File: tb/tb_mbist_ctrl_n.sv
// Directed bench for mbist_ctrl_n (2 banks, 16 words x 8 bits) with a behavioural RAM model.
module tb_mbist_ctrl_n;

    localparam int NB = 2;
    localparam int AW = 4;
    localparam int DW = 8;
    localparam int LOGN = 512;

    logic          clk = 1'b0;
    logic          bist_reset = 1'b1;
    logic          test_mode = 1'b0;
    logic [1:0]    bist_mode = 2'b00;
    logic [NB*DW-1:0] bank_rdata = '0;
    logic [AW-1:0] bist_addr;
    logic [DW-1:0] bist_wdata;
    logic          bist_we;
    logic          bist_on;
    logic          done;
    logic          error;
    logic [NB-1:0] fail_bank;
    logic [AW-1:0] fail_addr;

    int n_checks = 0;
    int n_fail = 0;
    logic fault = 1'b0;
    int done_cyc;
    logic [DW-1:0] log_wd [LOGN];
    logic [AW-1:0] log_ad [LOGN];
    logic          log_we [LOGN];
    logic          log_on [LOGN];
    logic [DW-1:0] mem [NB][16];

    mbist_ctrl_n #(
        .NUM_BANKS(NB),
        .ADDR_W   (AW),
        .DATA_W   (DW)
    ) dut (
        .clk       (clk),
        .bist_reset(bist_reset),
        .test_mode (test_mode),
        .bist_mode (bist_mode),
        .bank_rdata(bank_rdata),
        .bist_addr (bist_addr),
        .bist_wdata(bist_wdata),
        .bist_we   (bist_we),
        .bist_on   (bist_on),
        .done      (done),
        .error     (error),
        .fail_bank (fail_bank),
        .fail_addr (fail_addr)
    );

    always #5 clk = ~clk;

    // Synchronous RAM, read latency 1; optional bank1 addr5 bit3 stuck-at-1.
    always @(posedge clk) begin
        logic [DW-1:0] rd;
        for (int b = 0; b < NB; b++) begin
            rd = mem[b][bist_addr];
            if (fault && b == 1 && bist_addr == 4'd5) rd[3] = 1'b1;
            if (bist_we) mem[b][bist_addr] <= bist_wdata;
            bank_rdata[b*DW +: DW] <= rd;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        bist_reset = 1'b1;
        test_mode = 1'b0;
        bist_mode = 2'b00;
        step();
        bist_reset = 1'b0;
    endtask

    // Start edge is cycle 0; logs outputs after each following edge until done.
    task automatic run(input logic [1:0] mode);
        int cnt;
        bist_mode = mode;
        test_mode = 1'b1;
        step();
        cnt = 0;
        done_cyc = -1;
        while (done_cyc < 0 && cnt < LOGN - 1) begin
            step();
            cnt++;
            log_wd[cnt] = bist_wdata;
            log_ad[cnt] = bist_addr;
            log_we[cnt] = bist_we;
            log_on[cnt] = bist_on;
            if (done) done_cyc = cnt;
        end
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++;
        if ({bist_on, bist_we, done, error} !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_ctrl: got on/we/done/err=%b want 0000", {bist_on, bist_we, done, error});
        end
        n_checks++;
        if ({bist_addr, bist_wdata, fail_bank, fail_addr} !== '0) begin
            n_fail++;
            $display("FAIL reset_data: got addr=%h wd=%h fb=%b fa=%h want all 0",
                     bist_addr, bist_wdata, fail_bank, fail_addr);
        end
    endtask

    task automatic test_solid();
        int bad;
        do_reset();
        run(2'b01);
        n_checks++;
        if (done_cyc !== 162) begin
            n_fail++;
            $display("FAIL solid_done_cycle: got %0d want 162", done_cyc);
        end
        bad = 0;
        for (int i = 1; i <= 16; i++) begin
            if (log_we[i] !== 1'b1 || log_wd[i] !== 8'h00 || log_ad[i] !== 4'(i - 1)) bad++;
        end
        n_checks++;
        if (bad !== 0) begin
            n_fail++;
            $display("FAIL solid_m0_writes: got %0d bad ops want 0", bad);
        end
        n_checks++;
        if ({log_we[17], log_ad[17], log_we[18], log_wd[18], log_ad[18]} !== {1'b0, 4'h0, 1'b1, 8'hFF, 4'h0}) begin
            n_fail++;
            $display("FAIL solid_m1_r0w1: got we=%b a=%h / we=%b wd=%h a=%h want 0 0 / 1 ff 0",
                     log_we[17], log_ad[17], log_we[18], log_wd[18], log_ad[18]);
        end
        n_checks++;
        if ({log_ad[81], log_we[81], log_wd[82], log_we[82], log_ad[83]} !== {4'hF, 1'b0, 8'hFF, 1'b1, 4'hE}) begin
            n_fail++;
            $display("FAIL solid_m3_down: got a=%h we=%b wd=%h we=%b a=%h want f 0 ff 1 e",
                     log_ad[81], log_we[81], log_wd[82], log_we[82], log_ad[83]);
        end
        n_checks++;
        if ({error, fail_bank} !== 3'b000) begin
            n_fail++;
            $display("FAIL solid_clean: got err=%b fb=%b want 0 00", error, fail_bank);
        end
        // Leaving DONE via bist_mode=00 drops done.
        bist_mode = 2'b00;
        step();
        step();
        n_checks++;
        if (done !== 1'b0) begin
            n_fail++;
            $display("FAIL done_clear: got %b want 0", done);
        end
    endtask

    task automatic test_checker();
        do_reset();
        run(2'b10);
        n_checks++;
        if ({log_wd[1], log_wd[2], log_wd[3]} !== {8'h55, 8'hAA, 8'h55}) begin
            n_fail++;
            $display("FAIL checker_m0: got %h %h %h want 55 aa 55", log_wd[1], log_wd[2], log_wd[3]);
        end
        n_checks++;
        if ({log_we[18], log_wd[18]} !== {1'b1, 8'hAA}) begin
            n_fail++;
            $display("FAIL checker_m1_w1: got we=%b wd=%h want 1 aa", log_we[18], log_wd[18]);
        end
        n_checks++;
        if (done_cyc !== 162 || error !== 1'b0) begin
            n_fail++;
            $display("FAIL checker_done: got cyc=%0d err=%b want 162 0", done_cyc, error);
        end
    endtask

    task automatic test_fault();
        do_reset();
        fault = 1'b1;
        run(2'b01);
        fault = 1'b0;
`ifdef MBIST_STOP_ON_FAIL_EN
        n_checks++;
        if (done_cyc !== 30) begin
            n_fail++;
            $display("FAIL fault_stop_done: got %0d want 30", done_cyc);
        end
        step();
        n_checks++;
        if (bist_on !== 1'b0) begin
            n_fail++;
            $display("FAIL fault_stop_on: got %b want 0", bist_on);
        end
`else
        n_checks++;
        if (done_cyc !== 162) begin
            n_fail++;
            $display("FAIL fault_done_cycle: got %0d want 162", done_cyc);
        end
`endif
        n_checks++;
        if ({error, fail_bank, fail_addr} !== {1'b1, 2'b10, 4'h5}) begin
            n_fail++;
            $display("FAIL fault_capture: got err=%b fb=%b fa=%h want 1 10 5", error, fail_bank, fail_addr);
        end
    endtask

    task automatic test_mid_reset();
        do_reset();
        bist_mode = 2'b01;
        test_mode = 1'b1;
        for (int i = 0; i < 51; i++) step();
        bist_reset = 1'b1;
        step();
        bist_reset = 1'b0;
        n_checks++;
        if ({bist_on, bist_we, bist_addr, fail_bank, done} !== '0) begin
            n_fail++;
            $display("FAIL midrst_outputs: got on=%b we=%b a=%h fb=%b done=%b want all 0",
                     bist_on, bist_we, bist_addr, fail_bank, done);
        end
        run(2'b01);
        n_checks++;
        if (done_cyc !== 162 || error !== 1'b0) begin
            n_fail++;
            $display("FAIL midrst_restart: got cyc=%0d err=%b want 162 0", done_cyc, error);
        end
    endtask

    task automatic test_idle_both();
        int on_seen;
        do_reset();
        bist_mode = 2'b11;
        test_mode = 1'b0;
        on_seen = 0;
        for (int i = 0; i < 400; i++) begin
            step();
            if (bist_on !== 1'b0 || done !== 1'b0) on_seen++;
        end
        n_checks++;
        if (on_seen !== 0) begin
            n_fail++;
            $display("FAIL idle_hold: got %0d active cycles want 0", on_seen);
        end
        run(2'b11);
        n_checks++;
        if (done_cyc !== 324) begin
            n_fail++;
            $display("FAIL both_done_cycle: got %0d want 324", done_cyc);
        end
        n_checks++;
        if ({log_we[162], log_on[162]} !== {1'b0, 1'b1}) begin
            n_fail++;
            $display("FAIL both_gap: got we=%b on=%b want 0 1", log_we[162], log_on[162]);
        end
        n_checks++;
        if ({log_we[163], log_wd[163], log_ad[163], log_wd[164], log_ad[164]}
            !== {1'b1, 8'h55, 4'h0, 8'hAA, 4'h1}) begin
            n_fail++;
            $display("FAIL both_checker_start: got we=%b wd=%h a=%h wd=%h a=%h want 1 55 0 aa 1",
                     log_we[163], log_wd[163], log_ad[163], log_wd[164], log_ad[164]);
        end
        n_checks++;
        if ({error, fail_bank} !== 3'b000) begin
            n_fail++;
            $display("FAIL both_clean: got err=%b fb=%b want 0 00", error, fail_bank);
        end
    endtask

    initial begin
        test_reset();
        test_solid();
        test_checker();
        test_fault();
        test_mid_reset();
        test_idle_both();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
